// File: rtl/sdram_traffic_gen.sv
// sdram_traffic_gen
//   Self-test initiator for the SDRAM_Controller user interface. Writes a
//   deterministic pattern over [ADR_START..ADR_END], reads the window back,
//   and compares each word. It reports pass/fail/timeout, the first failing
//   address and a saturating miscompare count.
//
// Ports
//   global_CLK, global_nRST          clock, synchronous active-low reset
//   test_startTrig                   start pulse (honoured in IDLE/DONE)
//   test_busyFlag                    run in progress
//   test_passFlag / test_failFlag    result, valid in DONE
//   test_timeoutFlag                 a controller busy flag never rose
//   ERR_ADR, ERR_CNT                 first failing address, miscompare count
//   wt_startTrig, WT_ADR, WT_DATA    write request to the controller
//   wt_busyFlag                      controller write busy
//   rd_startTrig, RD_ADR             read request to the controller
//   RD_DATA, rd_busyFlag             controller read data / read busy
//
// Build option
//   SDRAM_TGEN_LFSR_PATTERN_EN: when defined, data comes from a 16-bit
//   Fibonacci LFSR (x^16+x^14+x^13+x^11+1) seeded with SEED (0 -> 1).
//   When undefined, data = ADR[15:0] ^ SEED.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for a start
// WR_REQ  | wait for write busy low, then pulse wt_startTrig
// WR_ACK  | wait for write busy to rise (timeout-guarded)
// WR_WAIT | wait for write busy to fall, then next address or read pass
// RD_REQ  | wait for read busy low, then pulse rd_startTrig
// RD_ACK  | wait for read busy to rise (timeout-guarded)
// RD_WAIT | wait for read busy to fall, capture RD_DATA
// CMP     | compare captured data against the expected pattern
// DONE    | result flags held until reset or the next start

module sdram_traffic_gen #(
  parameter logic [23:0] ADR_START   = 24'h000000,
  parameter logic [23:0] ADR_END     = 24'h0000FF,
  parameter logic [15:0] SEED        = 16'hA5A5,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic        global_CLK,
  input  logic        global_nRST,
  input  logic        test_startTrig,
  output logic        test_busyFlag,
  output logic        test_passFlag,
  output logic        test_failFlag,
  output logic        test_timeoutFlag,
  output logic [23:0] ERR_ADR,
  output logic [7:0]  ERR_CNT,
  output logic        wt_startTrig,
  output logic [23:0] WT_ADR,
  output logic [15:0] WT_DATA,
  input  logic        wt_busyFlag,
  output logic        rd_startTrig,
  output logic [23:0] RD_ADR,
  input  logic [15:0] RD_DATA,
  input  logic        rd_busyFlag
);

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_ACK, WR_WAIT, RD_REQ, RD_ACK, RD_WAIT, CMP, DONE
  } state_t;

  // Ack timer is a down-counter: loaded with ACK_TIMEOUT-1 on a trigger, so
  // the value 0 marks the ACK_TIMEOUT-th cycle spent waiting for busy.
  localparam logic [7:0] L_ACK_LOAD = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [23:0] r_adr;
  logic [7:0]  r_ack_cnt;
  logic [7:0]  r_err_cnt;
  logic [23:0] r_err_adr;
  logic        r_timeout;
  logic [15:0] r_rd_data;
  logic [15:0] w_pat;

  logic w_accept, w_advance, w_rewind, w_ack_load, w_ack_run;
  logic w_to, w_cap_rd, w_miscmp, w_wt_trig, w_rd_trig;
  logic w_last, w_ack_exp;

  assign w_last    = (r_adr == ADR_END);
  assign w_ack_exp = (r_ack_cnt == 8'd0);

`ifdef SDRAM_TGEN_LFSR_PATTERN_EN
  localparam logic [15:0] L_LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  logic [15:0] r_lfsr;
  logic        w_fb;
  assign w_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_pat = r_lfsr;

  always_ff @(posedge global_CLK) begin
    if (!global_nRST) begin
      r_lfsr <= L_LFSR_INIT;
    end else if (w_accept || w_rewind) begin
      r_lfsr <= L_LFSR_INIT;
    end else if (w_advance) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
`else
  assign w_pat = r_adr[15:0] ^ SEED;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_rewind    = 1'b0;
    w_ack_run   = 1'b0;
    w_to        = 1'b0;
    w_cap_rd    = 1'b0;
    w_miscmp    = 1'b0;
    w_wt_trig   = 1'b0;
    w_rd_trig   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (test_startTrig) begin
          w_accept    = 1'b1;
          w_state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!wt_busyFlag) begin
          w_wt_trig   = 1'b1;
          w_state_nxt = WR_ACK;
        end
      end
      WR_ACK: begin
        if (wt_busyFlag) begin
          w_state_nxt = WR_WAIT;
        end else if (w_ack_exp) begin
          w_to        = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_ack_run = 1'b1;
        end
      end
      WR_WAIT: begin
        if (!wt_busyFlag) begin
          if (w_last) begin
            w_rewind    = 1'b1;
            w_state_nxt = RD_REQ;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!rd_busyFlag) begin
          w_rd_trig   = 1'b1;
          w_state_nxt = RD_ACK;
        end
      end
      RD_ACK: begin
        if (rd_busyFlag) begin
          w_state_nxt = RD_WAIT;
        end else if (w_ack_exp) begin
          w_to        = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_ack_run = 1'b1;
        end
      end
      RD_WAIT: begin
        if (!rd_busyFlag) begin
          w_cap_rd    = 1'b1;
          w_state_nxt = CMP;
        end
      end
      CMP: begin
        w_miscmp = (r_rd_data != w_pat);
        if (w_miscmp && STOP_ON_ERR) begin
          w_state_nxt = DONE;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = RD_REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ack_load = w_wt_trig | w_rd_trig;

  always_ff @(posedge global_CLK) begin
    if (!global_nRST) begin
      r_state   <= IDLE;
      r_adr     <= ADR_START;
      r_ack_cnt <= 8'd0;
      r_err_cnt <= 8'd0;
      r_err_adr <= 24'd0;
      r_timeout <= 1'b0;
      r_rd_data <= 16'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept || w_rewind) begin
        r_adr <= ADR_START;
      end else if (w_advance) begin
        r_adr <= r_adr + 24'd1;
      end

      if (w_accept) begin
        r_ack_cnt <= 8'd0;
      end else if (w_ack_load) begin
        r_ack_cnt <= L_ACK_LOAD;
      end else if (w_ack_run) begin
        r_ack_cnt <= r_ack_cnt - 8'd1;
      end

      if (w_accept) begin
        r_err_cnt <= 8'd0;
        r_err_adr <= 24'd0;
        r_timeout <= 1'b0;
      end else if (w_to) begin
        r_timeout <= 1'b1;
        r_err_adr <= r_adr;
      end else if (w_miscmp) begin
        if (r_err_cnt == 8'd0) begin
          r_err_adr <= r_adr;
        end
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end

      if (w_cap_rd) begin
        r_rd_data <= RD_DATA;
      end
    end
  end

  logic w_in_wr, w_in_rd, w_done;
  assign w_in_wr = (r_state == WR_REQ) || (r_state == WR_ACK) || (r_state == WR_WAIT);
  assign w_in_rd = (r_state == RD_REQ) || (r_state == RD_ACK) || (r_state == RD_WAIT);
  assign w_done  = (r_state == DONE);

  assign test_busyFlag    = (r_state != IDLE) && !w_done;
  assign test_timeoutFlag = w_done && r_timeout;
  assign test_failFlag    = w_done && (r_timeout || (r_err_cnt != 8'd0));
  assign test_passFlag    = w_done && !r_timeout && (r_err_cnt == 8'd0);
  assign ERR_ADR          = r_err_adr;
  assign ERR_CNT          = r_err_cnt;

  // Addresses/data are only presented while the matching pass is active so
  // the controller sees quiet buses in IDLE and DONE.
  assign wt_startTrig = w_wt_trig;
  assign WT_ADR       = w_in_wr ? r_adr : 24'd0;
  assign WT_DATA      = w_in_wr ? w_pat : 16'd0;
  assign rd_startTrig = w_rd_trig;
  assign RD_ADR       = w_in_rd ? r_adr : 24'd0;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
module tb_sdram_traffic_gen;

`ifdef SDRAM_TGEN_LFSR_PATTERN_EN
  localparam logic [15:0] P_SEED = 16'h0000;
  // LFSR from 0x0001: taps 15,13,12,10 stay zero for the first shifts.
  localparam logic [15:0] PAT [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
`else
  localparam logic [15:0] P_SEED = 16'hA5A5;
  localparam logic [15:0] PAT [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
`endif
  localparam int P_ACK_TO = 16;

  typedef struct packed {
    logic        rd;
    logic [23:0] adr;
    logic [15:0] dat;
  } trig_t;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        tout;
    logic [23:0] eadr;
    logic [7:0]  ecnt;
  } stat_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start   [2];
  logic        busy    [2];
  logic        pass    [2];
  logic        fail    [2];
  logic        tout    [2];
  logic [23:0] err_adr [2];
  logic [7:0]  err_cnt [2];
  logic        wt_trig [2];
  logic [23:0] wt_adr  [2];
  logic [15:0] wt_dat  [2];
  logic        rd_trig [2];
  logic [23:0] rd_adr  [2];
  logic [3:0]  corrupt [2];
  logic        no_ack  [2];

  trig_t q_trig[$];
  stat_t q_stat[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    act = 0;
  bit    in_reset = 1'b1;

  // Instance 0 stops at the first miscompare, instance 1 runs to ADR_END.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        wbusy = 1'b0;
    logic        rbusy = 1'b0;
    logic [1:0]  wcnt = 2'd0;
    logic [1:0]  rcnt = 2'd0;
    logic [15:0] rdat = 16'h0;
    logic [15:0] mem [4] = '{default: 16'h0};

    sdram_traffic_gen #(
      .ADR_START  (24'h000000),
      .ADR_END    (24'h000003),
      .SEED       (P_SEED),
      .ACK_TIMEOUT(P_ACK_TO),
      .STOP_ON_ERR(g == 0)
    ) u_dut (
      .global_CLK      (clk),
      .global_nRST     (nrst),
      .test_startTrig  (start[g]),
      .test_busyFlag   (busy[g]),
      .test_passFlag   (pass[g]),
      .test_failFlag   (fail[g]),
      .test_timeoutFlag(tout[g]),
      .ERR_ADR         (err_adr[g]),
      .ERR_CNT         (err_cnt[g]),
      .wt_startTrig    (wt_trig[g]),
      .WT_ADR          (wt_adr[g]),
      .WT_DATA         (wt_dat[g]),
      .wt_busyFlag     (wbusy),
      .rd_startTrig    (rd_trig[g]),
      .RD_ADR          (rd_adr[g]),
      .RD_DATA         (rdat),
      .rd_busyFlag     (rbusy)
    );

    // Ideal controller: busy rises the cycle after a trigger, stays high 4 cycles.
    always @(posedge clk) begin
      if (wt_trig[g] && !no_ack[g]) begin
        wbusy <= 1'b1;
        wcnt  <= 2'd3;
        mem[wt_adr[g][1:0]] <= wt_dat[g];
      end else if (wcnt != 2'd0) begin
        wcnt <= wcnt - 2'd1;
      end else begin
        wbusy <= 1'b0;
      end
      if (rd_trig[g]) begin
        rbusy <= 1'b1;
        rcnt  <= 2'd3;
        rdat  <= corrupt[g][rd_adr[g][1:0]] ? 16'h0000 : mem[rd_adr[g][1:0]];
      end else if (rcnt != 2'd0) begin
        rcnt <= rcnt - 2'd1;
      end else begin
        rbusy <= 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the active DUT issues a trigger or finishes.
  logic prev_trig = 1'b0;
  logic prev_busy = 1'b0;
  initial begin
    trig_t et, gt;
    stat_t es, gs;
    forever begin
      @(negedge clk);
      if (wt_trig[act] || rd_trig[act]) begin
        n_vec++;
        if (wt_trig[act] && rd_trig[act]) begin
          n_err++;
          $display("FAIL trig_exclusive: got wt=1 rd=1 expected at most one");
        end
        n_vec++;
        if (prev_trig) begin
          n_err++;
          $display("FAIL trig_consecutive: got trigger in back-to-back cycles at cycle %0d", cyc);
        end
        gt = rd_trig[act] ? trig_t'{1'b1, rd_adr[act], 16'h0} : trig_t'{1'b0, wt_adr[act], wt_dat[act]};
        n_vec++;
        if (q_trig.size() == 0) begin
          n_err++;
          $display("FAIL trig_unexpected: got %h expected no trigger", gt);
        end else begin
          et = q_trig.pop_front();
          if (gt !== et) begin
            n_err++;
            $display("FAIL trig: got rd=%b adr=%h dat=%h expected rd=%b adr=%h dat=%h",
                     gt.rd, gt.adr, gt.dat, et.rd, et.adr, et.dat);
          end
        end
      end
      prev_trig = wt_trig[act] || rd_trig[act];
      if (prev_busy && !busy[act] && !in_reset) begin
        gs = stat_t'{pass[act], fail[act], tout[act], err_adr[act], err_cnt[act]};
        n_vec++;
        if (q_stat.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected: got %h expected no completion", gs);
        end else begin
          es = q_stat.pop_front();
          if (gs !== es) begin
            n_err++;
            $display("FAIL status: got p=%b f=%b t=%b eadr=%h ecnt=%0d expected p=%b f=%b t=%b eadr=%h ecnt=%0d",
                     gs.pass, gs.fail, gs.tout, gs.eadr, gs.ecnt, es.pass, es.fail, es.tout, es.eadr, es.ecnt);
          end
        end
      end
      prev_busy = busy[act];
    end
  end

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) q_trig.push_back(trig_t'{1'b0, 24'(i), PAT[i]});
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) q_trig.push_back(trig_t'{1'b1, 24'(i), 16'h0});
  endtask

  task automatic push_stat(input logic p, input logic f, input logic t,
                           input logic [23:0] ea, input logic [7:0] ec);
    q_stat.push_back(stat_t'{p, f, t, ea, ec});
  endtask

  task automatic pulse_start(input int a);
    @(negedge clk);
    start[a] = 1'b1;
    @(negedge clk);
    start[a] = 1'b0;
  endtask

  task automatic wait_done(input int a, input string tag);
    bit seen;
    bit done;
    seen = busy[a];
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (busy[a]) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_done_timeout: got busy=%b expected completion within 1000 cycles", tag, busy[a]);
    end
  endtask

  task automatic finish_test(input string tag);
    repeat (6) @(negedge clk);
    n_vec++;
    if (q_trig.size() != 0 || q_stat.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover: got %0d triggers %0d results pending expected 0 0",
               tag, q_trig.size(), q_stat.size());
    end
    q_trig.delete();
    q_stat.delete();
  endtask

  task automatic check_zero(input int a, input string tag);
    logic [124:0] got;
    got = {busy[a], pass[a], fail[a], tout[a], err_adr[a], err_cnt[a],
           wt_trig[a], wt_adr[a], wt_dat[a], rd_trig[a], rd_adr[a]};
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL %s: got outputs %h expected all zero", tag, got);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      corrupt[g] = 4'b0000;
      no_ack[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    nrst = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;

    // Clean pass, with a start pulse while busy that must be ignored.
    act = 0;
    push_writes(4); push_reads(4); push_stat(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    pulse_start(0);
    repeat (8) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, "clean");
    finish_test("clean");

    // Stop at first miscompare: address 2 corrupted, no read of address 3.
    corrupt[0] = 4'b0100;
    push_writes(4); push_reads(3); push_stat(1'b0, 1'b1, 1'b0, 24'h000002, 8'd1);
    pulse_start(0);
    wait_done(0, "stop_err");
    finish_test("stop_err");
    corrupt[0] = 4'b0000;

    // Run to the end: addresses 1 and 3 corrupted.
    act = 1;
    corrupt[1] = 4'b1010;
    push_writes(4); push_reads(4); push_stat(1'b0, 1'b1, 1'b0, 24'h000001, 8'd2);
    pulse_start(1);
    wait_done(1, "cont_err");
    finish_test("cont_err");
    corrupt[1] = 4'b0000;

    // Write never acknowledged: timeout on address 0, no reads.
    act = 0;
    no_ack[0] = 1'b1;
    push_writes(1); push_stat(1'b0, 1'b1, 1'b1, 24'h000000, 8'd0);
    pulse_start(0);
    n = 0;
    while (!wt_trig[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n = 0;
    while (busy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    // 16 waiting cycles after the trigger cycle, then DONE.
    n_vec++;
    if (t1 - t0 != P_ACK_TO + 1) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", t1 - t0, P_ACK_TO + 1);
    end
    finish_test("timeout");
    no_ack[0] = 1'b0;

    // Reset in RD_WAIT of address 1, then a full rerun.
    push_writes(4); push_reads(4); push_stat(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    pulse_start(0);
    n = 0;
    for (int i = 0; i < 500 && n < 2; i++) begin
      @(negedge clk);
      if (rd_trig[0]) n++;
    end
    n_vec++;
    if (n != 2) begin
      n_err++;
      $display("FAIL reset_setup: got %0d reads expected 2", n);
    end
    @(negedge clk);
    @(negedge clk);
    in_reset = 1'b1;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check_zero(0, "reset_midrun");
    q_trig.delete();
    q_stat.delete();
    @(negedge clk);
    in_reset = 1'b0;
    push_writes(4); push_reads(4); push_stat(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    pulse_start(0);
    wait_done(0, "rerun");
    finish_test("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
